// File: rtl/wpn_pkg.sv
// Shared definitions for the melee weapon blocks.
// Holds the attack state encoding and the default timing and geometry
// constants, so that wpn_melee_attack_ctrl and wpn_draw_melee agree on them.
package wpn_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WINDUP     = 3'd1,
    SWING_FWD  = 3'd2,
    SWING_BACK = 3'd3,
    COOLDOWN   = 3'd4
  } melee_state_t;

  localparam int WPN_WINDUP_FRAMES   = 2;
  localparam int WPN_SWING_FRAMES    = 10;
  localparam int WPN_STEP_PX         = 2;
  localparam int WPN_COOLDOWN_FRAMES = 15;
  localparam int WPN_Y_OFS           = 4;

  // Frame counter width: it must hold the largest per-state tick count.
  function automatic int wpn_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for a level input that is already in the clk domain.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   i_d       level input
//   o_rise    high in the cycle where i_d is 1 and was 0 on the previous clk
// o_rise is combinational from i_d, so the consumer sees the edge in the
// same cycle and can register its reaction on the next edge.
module edge_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_d_q;

  always_ff @(posedge clk) begin
    if (rst) r_d_q <= 1'b0;
    else     r_d_q <= i_d;
  end

  assign o_rise = i_d & ~r_d_q;

endmodule

// File: rtl/wpn_melee_attack_ctrl.sv
// Melee attack sequencer: click edge -> windup -> forward swing -> return
// -> cooldown. Drives the weapon drawer (visibility, facing, sprite offset)
// and exports the damage window to hit detection.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_frame_tick          one-cycle pulse per video frame
//   i_mouse_clicked       attack button level
//   i_flip_h              character facing, 1 = left
//   i_pos_x/y_wpn         weapon anchor (hand position)
//   o_pos_x/y_wpn_offset  sprite centre for the drawer (mod 4096)
//   o_wpn_visible         drawer enable
//   o_wpn_flip            facing latched at attack start
//   o_hit_active          damage window, high throughout SWING_FWD
//   o_attack_busy         high whenever not IDLE
//   o_attack_start        one-cycle pulse when an attack enters WINDUP
// All outputs are registered from the next-state values, so they line up
// with the state register and lag the causing input by one clk.
module wpn_melee_attack_ctrl
  import wpn_pkg::*;
#(
  parameter int WINDUP_FRAMES   = WPN_WINDUP_FRAMES,
  parameter int SWING_FRAMES    = WPN_SWING_FRAMES,
  parameter int STEP_PX         = WPN_STEP_PX,
  parameter int COOLDOWN_FRAMES = WPN_COOLDOWN_FRAMES,
  parameter int Y_OFS           = WPN_Y_OFS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic        i_mouse_clicked,
  input  logic        i_flip_h,
  input  logic [11:0] i_pos_x_wpn,
  input  logic [11:0] i_pos_y_wpn,
  output logic [11:0] o_pos_x_wpn_offset,
  output logic [11:0] o_pos_y_wpn_offset,
  output logic        o_wpn_visible,
  output logic        o_wpn_flip,
  output logic        o_hit_active,
  output logic        o_attack_busy,
  output logic        o_attack_start
);

  localparam int CNT_W = wpn_cnt_width(WINDUP_FRAMES, SWING_FRAMES, COOLDOWN_FRAMES);

  localparam logic [CNT_W-1:0] WINDUP_LAST   = CNT_W'(WINDUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] SWING_LAST    = CNT_W'(SWING_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [11:0]      STEP12        = 12'(STEP_PX);
  localparam logic [11:0]      Y_OFS12       = 12'(Y_OFS);

  melee_state_t     r_state;
  logic [CNT_W-1:0] r_fcnt;
  logic [11:0]      r_anim_off;
  logic             r_pend;
  logic             r_flip;

  melee_state_t     w_state_next;
  logic [CNT_W-1:0] w_fcnt_next;
  logic [11:0]      w_anim_next;
  logic             w_pend_next;
  logic             w_flip_next;
  logic             w_start;
  logic             w_rise;
  logic             w_visible_next;
  logic [11:0]      w_pos_x_next;

  edge_rise_det u_click_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (i_mouse_clicked),
    .o_rise (w_rise)
  );

  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    w_anim_next  = r_anim_off;
    w_pend_next  = r_pend;
    w_flip_next  = r_flip;
    w_start      = 1'b0;

    case (r_state)
      IDLE: begin
        // A tick arriving with the click is not counted toward the windup.
        w_fcnt_next = '0;
        w_anim_next = '0;
        if (w_rise) begin
          w_state_next = WINDUP;
          w_flip_next  = i_flip_h;
          w_start      = 1'b1;
        end
      end

      WINDUP: begin
        if (i_frame_tick) begin
          if (r_fcnt == WINDUP_LAST) begin
            w_state_next = SWING_FWD;
            w_fcnt_next  = '0;
          end else begin
            w_fcnt_next = r_fcnt + 1'b1;
          end
        end
      end

      SWING_FWD: begin
        if (i_frame_tick) begin
          w_anim_next = r_anim_off + STEP12;
          if (r_fcnt == SWING_LAST) begin
            w_state_next = SWING_BACK;
            w_fcnt_next  = '0;
          end else begin
            w_fcnt_next = r_fcnt + 1'b1;
          end
        end
      end

      SWING_BACK: begin
        // The return ends on the tick that brings the offset back to zero;
        // "<=" also covers a zero step without underflowing.
        if (i_frame_tick) begin
          if (r_anim_off <= STEP12) begin
            w_anim_next  = '0;
            w_state_next = COOLDOWN;
            w_fcnt_next  = '0;
          end else begin
            w_anim_next = r_anim_off - STEP12;
            w_fcnt_next = r_fcnt + 1'b1;
          end
        end
      end

      COOLDOWN: begin
        if (w_rise) w_pend_next = 1'b1;
        if (i_frame_tick) begin
          if (r_fcnt == COOLDOWN_LAST) begin
            w_fcnt_next = '0;
            // A click queued during cooldown (including this very cycle)
            // chains straight into the next windup without an IDLE cycle.
            if (r_pend || w_rise) begin
              w_state_next = WINDUP;
              w_pend_next  = 1'b0;
              w_flip_next  = i_flip_h;
              w_start      = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_fcnt_next = r_fcnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_fcnt_next  = '0;
        w_anim_next  = '0;
        w_pend_next  = 1'b0;
      end
    endcase

    w_visible_next = (w_state_next == WINDUP) || (w_state_next == SWING_FWD) ||
                     (w_state_next == SWING_BACK);
    w_pos_x_next   = w_flip_next ? (i_pos_x_wpn - w_anim_next)
                                 : (i_pos_x_wpn + w_anim_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= IDLE;
      r_fcnt             <= '0;
      r_anim_off         <= '0;
      r_pend             <= 1'b0;
      r_flip             <= 1'b0;
      o_pos_x_wpn_offset <= '0;
      o_pos_y_wpn_offset <= '0;
      o_wpn_visible      <= 1'b0;
      o_hit_active       <= 1'b0;
      o_attack_busy      <= 1'b0;
      o_attack_start     <= 1'b0;
    end else begin
      r_state            <= w_state_next;
      r_fcnt             <= w_fcnt_next;
      r_anim_off         <= w_anim_next;
      r_pend             <= w_pend_next;
      r_flip             <= w_flip_next;
      o_pos_x_wpn_offset <= w_pos_x_next;
      o_pos_y_wpn_offset <= i_pos_y_wpn - Y_OFS12;
      o_wpn_visible      <= w_visible_next;
      o_hit_active       <= (w_state_next == SWING_FWD);
      o_attack_busy      <= (w_state_next != IDLE);
      o_attack_start     <= w_start;
    end
  end

  assign o_wpn_flip = r_flip;

endmodule

// File: tb/tb_wpn_melee_attack_ctrl.sv
// Self-checking bench for wpn_melee_attack_ctrl: a stimulus process drives
// inputs on the falling edge and pushes the expected outputs for the next
// rising edge into a queue; a monitor pops and compares each cycle.
module tb_wpn_melee_attack_ctrl;

  localparam int W    = 2;
  localparam int S    = 10;
  localparam int STEP = 2;
  localparam int C    = 15;
  localparam int YOFS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        btn = 1'b0;
  logic        flip_h = 1'b0;
  logic [11:0] px = '0;
  logic [11:0] py = '0;

  logic [11:0] x_ofs;
  logic [11:0] y_ofs;
  logic        vis, wflip, hit, busy, start;

  always #5 clk = ~clk;

  wpn_melee_attack_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .i_frame_tick       (tick),
    .i_mouse_clicked    (btn),
    .i_flip_h           (flip_h),
    .i_pos_x_wpn        (px),
    .i_pos_y_wpn        (py),
    .o_pos_x_wpn_offset (x_ofs),
    .o_pos_y_wpn_offset (y_ofs),
    .o_wpn_visible      (vis),
    .o_wpn_flip         (wflip),
    .o_hit_active       (hit),
    .o_attack_busy      (busy),
    .o_attack_start     (start)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        vis;
    logic        flip;
    logic        hit;
    logic        busy;
    logic        start;
  } out_t;

  out_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase_name = "reset";

  // Values the main sequence wants applied at the next falling edge.
  logic [11:0] s_px = '0;
  logic [11:0] s_py = '0;
  logic        s_flip = 1'b0;
  int          tick_period = 100;
  int          tick_cnt = 0;

  // Reference model: an attack is described only by the number of frame
  // ticks seen since it started; phase and offset follow from that count.
  bit m_active = 0;
  bit m_pend = 0;
  bit m_flip = 0;
  bit m_prev = 0;
  int m_k = 0;

  function automatic out_t model(input bit r, input bit t, input bit b,
                                 input bit fh, input logic [11:0] p_x,
                                 input logic [11:0] p_y);
    out_t e;
    bit   rise;
    int   anim;
    int   x;
    e = '0;
    if (r) begin
      m_active = 0; m_pend = 0; m_flip = 0; m_prev = 0; m_k = 0;
      return e;
    end
    rise   = b & ~m_prev;
    m_prev = b;
    if (!m_active) begin
      if (rise) begin
        m_active = 1; m_k = 0; m_flip = fh; e.start = 1'b1;
      end
    end else begin
      if (m_k >= W + 2*S && rise) m_pend = 1;
      if (t) begin
        m_k++;
        if (m_k == W + 2*S + C) begin
          if (m_pend) begin
            m_k = 0; m_pend = 0; m_flip = fh; e.start = 1'b1;
          end else begin
            m_active = 0;
          end
        end
      end
    end
    anim = 0;
    if (m_active) begin
      e.busy = 1'b1;
      if (m_k < W) begin
        e.vis = 1'b1;
      end else if (m_k < W + S) begin
        e.vis = 1'b1; e.hit = 1'b1; anim = (m_k - W) * STEP;
      end else if (m_k < W + 2*S) begin
        e.vis = 1'b1; anim = (W + 2*S - m_k) * STEP;
      end
    end
    e.flip = m_flip;
    x   = m_flip ? (int'(p_x) - anim) : (int'(p_x) + anim);
    e.x = 12'(((x % 4096) + 4096) % 4096);
    e.y = 12'(((int'(p_y) - YOFS) + 4096) % 4096);
    return e;
  endfunction

  task automatic cycle(input bit r, input bit b);
    @(negedge clk);
    rst    = r;
    btn    = b;
    px     = s_px;
    py     = s_py;
    flip_h = s_flip;
    if (tick_period > 0) begin
      tick     = (tick_cnt == tick_period - 1);
      tick_cnt = (tick_cnt + 1) % tick_period;
    end else begin
      tick = ($urandom_range(0, 3) == 0);
    end
    exp_q.push_back(model(r, tick, b, flip_h, px, py));
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per edge.
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{x: x_ofs, y: y_ofs, vis: vis, flip: wflip, hit: hit, busy: busy, start: start};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got x=%0d y=%0d vis=%b flip=%b hit=%b busy=%b start=%b, expected x=%0d y=%0d vis=%b flip=%b hit=%b busy=%b start=%b",
                   phase_name, $time, a.x, a.y, a.vis, a.flip, a.hit, a.busy, a.start,
                   e.x, e.y, e.vis, e.flip, e.hit, e.busy, e.start);
        end
      end
    end
  end

  initial begin
    // Reset, then a long quiet stretch.
    phase_name = "reset";
    repeat (3) cycle(1, 0);
    phase_name = "idle_no_click";
    s_px = 12'd123; s_py = 12'd45;
    repeat (1000) cycle(0, 0);

    // Single click facing right.
    phase_name = "single_click";
    s_px = 12'd300; s_py = 12'd200; s_flip = 1'b0;
    repeat (5) cycle(0, 1);
    repeat (3900) cycle(0, 0);

    // Facing left, facing input toggled mid-swing.
    phase_name = "flip_left";
    s_flip = 1'b1;
    repeat (5) cycle(0, 1);
    repeat (1200) cycle(0, 0);
    s_flip = 1'b0;
    repeat (2700) cycle(0, 0);

    // Click during SWING_FWD (dropped) and during COOLDOWN (queued).
    phase_name = "pend_chain";
    s_flip = 1'b0;
    repeat (3) cycle(0, 1);
    repeat (800) cycle(0, 0);
    repeat (3) cycle(0, 1);
    repeat (1700) cycle(0, 0);
    s_flip = 1'b1;
    repeat (3) cycle(0, 1);
    repeat (5000) cycle(0, 0);

    // Reset in the middle of SWING_FWD.
    phase_name = "rst_mid_swing";
    s_flip = 1'b0;
    repeat (3) cycle(0, 1);
    repeat (750) cycle(0, 0);
    cycle(1, 0);
    repeat (300) cycle(0, 0);

    // Reset while a click is queued in COOLDOWN must drop it.
    phase_name = "rst_clears_pend";
    tick_period = 10; tick_cnt = 0;
    repeat (3) cycle(0, 1);
    repeat (250) cycle(0, 0);
    repeat (3) cycle(0, 1);
    repeat (20) cycle(0, 0);
    cycle(1, 0);
    repeat (500) cycle(0, 0);

    // Offset wrap with the button held the whole time.
    phase_name = "wrap_hold";
    tick_period = 100; tick_cnt = 0;
    s_px = 12'd4090; s_py = 12'd2; s_flip = 1'b0;
    repeat (4000) cycle(0, 1);
    repeat (50) cycle(0, 0);

    // Randomized traffic with fast random ticks.
    phase_name = "random";
    tick_period = 0;
    begin
      bit b;
      b = 1'b0;
      for (int i = 0; i < 20000; i++) begin
        if ($urandom_range(0, 29) == 0) b = ~b;
        if ($urandom_range(0, 49) == 0) s_flip = ~s_flip;
        if ($urandom_range(0, 199) == 0) begin
          s_px = 12'($urandom_range(0, 4095));
          s_py = 12'($urandom_range(0, 4095));
        end
        cycle(($urandom_range(0, 2999) == 0), b);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
